timer: RTL
==========

// Module: timer
// PURPOSE
// - Memory-mapped RISC-V machine timer (mtime/mtimecmp) attached as a device on the system bus.
// - Sits downstream of the bus, alongside the RAM and GPIO devices.
// - Drives the core's irq_timer_i input with a level interrupt.
// - Provides a free-running 64-bit time base for software delays and the scheduler tick.
// PARAMETERS
// - DataWidth     32   bus data width; only 32 is supported.
// - AddressWidth  32   bus address width.
// - PrescaleWidth 16   width of the prescaler register. Used only with TIMER_PRESCALER_EN.
// PORTS
// - clk_i            in   1   system clock; the block has a single clock domain.
// - rst_ni           in   1   asynchronous active-low reset.
// - device_req_i     in   1   bus request; each request is a single-cycle pulse.
// - device_addr_i    in   32  byte address; only bits [4:2] are decoded.
// - device_we_i      in   1   1 = write, 0 = read.
// - device_be_i      in   4   byte enables for writes; ignored on reads.
// - device_wdata_i   in   32  write data.
// - device_rvalid_o  out  1   response strobe, asserted 1 cycle after every request.
// - device_rdata_o   out  32  read data, valid while device_rvalid_o=1.
// - timer_irq_o      out  1   level timer interrupt to the core.
// BEHAVIOUR
// - Register map (offset = addr[4:2]*4):
//   - 0x00 MTIME_LO
//   - 0x04 MTIME_HI
//   - 0x08 MTIMECMP_LO
//   - 0x0C MTIMECMP_HI
//   - 0x10 PRESCALE
//   - 0x14-0x1C: reads return 0, writes are ignored.
// - Reset values:
//   - mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, hi_shadow = 0.
//   - device_rvalid_o = 0, device_rdata_o = 0, timer_irq_o = 0.
// - Bus handshake:
//   - device_rvalid_o <= device_req_i, every cycle. There is no backpressure and no error.
//   - Read data is registered: it is captured on the request edge and presented with rvalid.
//   - Write responses return rvalid=1 with rdata=0.
// - Writes: byte-granular per device_be_i. Byte lanes with be=0 leave their bits unchanged.
// - Counter: mtime += 1 on every tick; 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
// - Counter write vs tick in the same cycle:
//   - The written half takes the written bytes.
//   - The other half keeps its old value; there is no increment that cycle.
//   - There is no carry into or out of the written half that cycle.
// - Atomic 64-bit read: a read of MTIME_LO captures mtime[63:32] into hi_shadow in the same cycle.
//   - A read of MTIME_HI returns hi_shadow, not the live value.
//   - Software reads LO then HI.
// - Interrupt: timer_irq_o <= (mtime >= mtimecmp), unsigned 64-bit compare, evaluated every cycle.
//   - Latency is 1 cycle from the register update to the irq change.
//   - The irq is a level signal; it clears only by writing mtimecmp > mtime or by the counter wrapping.
// - Reset asserted mid-operation: all state returns to its reset values immediately (asynchronously).
//   - An in-flight rvalid is dropped.
// CONFIGURATION
// - TIMER_PRESCALER_EN defined:
//   - PRESCALE is a read/write register at 0x10, reset value 0, PrescaleWidth bits, zero-extended on read.
//   - An internal counter pcnt (reset 0) increments each cycle.
//   - When pcnt == PRESCALE: tick=1 and pcnt <= 0.
//   - Tick period is therefore PRESCALE+1 cycles.
//   - A write to PRESCALE also clears pcnt.
//   - If PRESCALE is written to a value below pcnt, pcnt is cleared anyway; there is no long wait for wrap.
// - TIMER_PRESCALER_EN undefined:
//   - tick=1 every cycle.
//   - 0x10 reads 0; writes to it are ignored.
//   - No prescaler flops are instantiated.
// TESTING
// - Reset, then idle 10 cycles, then read MTIME_LO.
//   - Expect rvalid exactly 1 cycle after the req, rdata = 10 ± the fixed read offset, irq = 0.
// - Write MTIME_LO=32'hFFFF_FFFE and MTIME_HI=0, then wait 3 cycles.
//   - Expect a carry into HI: mtime = 64'h1_0000_0001.
//   - Then read LO followed by HI: HI returns the shadowed value 1, even if LO wraps again in between.
// - Write mtimecmp = 20 while mtime is about 5.
//   - Expect irq to rise on the cycle after mtime reaches 20.
//   - Write MTIMECMP_LO = 32'hFFFF_FFFF: expect irq to fall 1 cycle later.
// - Write MTIMECMP_LO with be=4'b0010, wdata=32'hAABBCCDD.
//   - Expect MTIMECMP_LO = 32'hFFFF_CCFF; the other bytes are untouched.
// - Issue back-to-back requests on consecutive cycles: write MTIME_LO=100, then read MTIME_LO.
//   - Expect two rvalid pulses; the read returns 100 (the write wins over the tick).
// - With TIMER_PRESCALER_EN, PRESCALE=3: expect mtime to advance 1 per 4 cycles.
//   - Without the macro: write 0x10=3, read it back as 0, and expect mtime to advance 1 per cycle.

Source files
------------

// File: rtl/timer.sv
// Memory-mapped RISC-V machine timer: 64-bit mtime/mtimecmp, level irq, atomic LO/HI read via shadow.
// Optional prescaler enabled with `define TIMER_PRESCALER_EN.
module timer #(
    parameter int DataWidth     = 32,
    parameter int AddressWidth  = 32,
    parameter int PrescaleWidth = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    device_req_i,
    input  logic [AddressWidth-1:0] device_addr_i,
    input  logic                    device_we_i,
    input  logic [3:0]              device_be_i,
    input  logic [DataWidth-1:0]    device_wdata_i,
    output logic                    device_rvalid_o,
    output logic [DataWidth-1:0]    device_rdata_o,
    output logic                    timer_irq_o
);

    localparam logic [2:0] A_MTIME_LO = 3'd0;
    localparam logic [2:0] A_MTIME_HI = 3'd1;
    localparam logic [2:0] A_CMP_LO   = 3'd2;
    localparam logic [2:0] A_CMP_HI   = 3'd3;
    localparam logic [2:0] A_PRESCALE = 3'd4;

    logic [63:0] r_mtime, r_mtimecmp;
    logic [31:0] r_hi_shadow;
    logic        r_rvalid, r_irq;
    logic [31:0] r_rdata;

    logic [2:0]  w_idx;
    logic        w_wr, w_rd, w_tick;
    logic [63:0] w_mtime_nxt;
    logic [31:0] w_rd_mux;
    logic        w_unused_addr;

    function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [3:0] be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            res[i*8 +: 8] = be[i] ? wd[i*8 +: 8] : old[i*8 +: 8];
        return res;
    endfunction

    assign w_idx         = device_addr_i[4:2];
    assign w_wr          = device_req_i & device_we_i;
    assign w_rd          = device_req_i & ~device_we_i;
    assign w_unused_addr = ^{device_addr_i[AddressWidth-1:5], device_addr_i[1:0]};

`ifdef TIMER_PRESCALER_EN
    logic [PrescaleWidth-1:0] r_prescale, r_pcnt;
    logic [PrescaleWidth-1:0] w_prescale_nxt;
    logic                     w_wr_pre;

    assign w_wr_pre = w_wr && (w_idx == A_PRESCALE);
    assign w_tick   = (r_pcnt == r_prescale);

    always_comb begin
        w_prescale_nxt = r_prescale;
        if (w_wr_pre)
            for (int i = 0; i < PrescaleWidth; i++)
                if (device_be_i[i/8]) w_prescale_nxt[i] = device_wdata_i[i];
    end

    // Any PRESCALE write restarts the period so a smaller value takes effect at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_prescale <= '0;
            r_pcnt     <= '0;
        end else begin
            r_prescale <= w_prescale_nxt;
            r_pcnt     <= (w_wr_pre || w_tick) ? '0 : r_pcnt + 1'b1;
        end
    end
`else
    logic [PrescaleWidth-1:0] w_unused_prescale;
    assign w_unused_prescale = '0;
    assign w_tick            = 1'b1;
`endif

    // A write to either mtime half suppresses the tick and any carry that cycle.
    always_comb begin
        w_mtime_nxt = r_mtime;
        if (w_wr && w_idx == A_MTIME_LO)
            w_mtime_nxt[31:0] = f_merge(r_mtime[31:0], device_wdata_i, device_be_i);
        else if (w_wr && w_idx == A_MTIME_HI)
            w_mtime_nxt[63:32] = f_merge(r_mtime[63:32], device_wdata_i, device_be_i);
        else if (w_tick)
            w_mtime_nxt = r_mtime + 64'd1;
    end

    always_comb begin
        w_rd_mux = '0;
        case (w_idx)
            A_MTIME_LO: w_rd_mux = r_mtime[31:0];
            A_MTIME_HI: w_rd_mux = r_hi_shadow;
            A_CMP_LO:   w_rd_mux = r_mtimecmp[31:0];
            A_CMP_HI:   w_rd_mux = r_mtimecmp[63:32];
`ifdef TIMER_PRESCALER_EN
            A_PRESCALE: w_rd_mux = 32'(r_prescale);
`endif
            default:    w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mtime     <= '0;
            r_mtimecmp  <= '1;
            r_hi_shadow <= '0;
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_mtime  <= w_mtime_nxt;
            r_rvalid <= device_req_i;
            r_rdata  <= w_rd ? w_rd_mux : '0;
            r_irq    <= (r_mtime >= r_mtimecmp);
            if (w_rd && w_idx == A_MTIME_LO) r_hi_shadow <= r_mtime[63:32];
            if (w_wr && w_idx == A_CMP_LO)
                r_mtimecmp[31:0] <= f_merge(r_mtimecmp[31:0], device_wdata_i, device_be_i);
            if (w_wr && w_idx == A_CMP_HI)
                r_mtimecmp[63:32] <= f_merge(r_mtimecmp[63:32], device_wdata_i, device_be_i);
        end
    end

    assign device_rvalid_o = r_rvalid;
    assign device_rdata_o  = r_rdata;
    assign timer_irq_o     = r_irq;

endmodule
